// File: rtl/control_unit.sv
// control_unit: hardwired multi-cycle sequencer for a simple load/store CPU.
// Ports: clk, clr (sync active-low reset), ir (opcode ir[31:27]), mem_ready;
//   outputs are memory strobes, bus-drive selects, register load strobes,
//   register-file select/encode controls, op_code (ALU op) and run.
// Optional: define MUL_DIV_EN to sequence mul/div through LO/HI.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        pc_out,
    output logic        zlo_out,
    output logic        zhi_out,
    output logic        mdr_out,
    output logic        pc_enable,
    output logic        pc_increment,
    output logic        mar_in,
    output logic        mdr_enable,
    output logic        mdr_read,
    output logic        ir_enable,
    output logic        y_enable,
    output logic        zlo_enable,
    output logic        zhi_enable,
    output logic        lo_enable,
    output logic        hi_enable,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        r_in,
    output logic        r_out,
    output logic        ba_out,
    output logic        c_out,
    output logic [4:0]  op_code,
    output logic        run
);

    localparam logic [3:0] S_RST  = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_T7   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    logic [3:0] state_q, state_d;
    logic [4:0] opc;
    logic       is_r, is_addi, is_ld, is_st, is_mem, is_md, is_halt;
    logic       rd_wait, mdr_en_st;
    logic       unused_ir;

    assign opc       = ir[31:27];
    assign unused_ir = ^ir[26:0];

    assign is_r    = (opc >= 5'd3) && (opc <= 5'd8);
    assign is_addi = (opc == 5'd12);
    assign is_ld   = (opc == 5'd0);
    assign is_st   = (opc == 5'd2);
    assign is_mem  = is_ld | is_st;
    assign is_halt = (opc == 5'd27);
`ifdef MUL_DIV_EN
    assign is_md   = (opc == 5'd15) || (opc == 5'd16);
`else
    assign is_md   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (mem_ready) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (is_halt)
                    state_d = S_HALT;
                else if (is_r | is_addi | is_mem | is_md)
                    state_d = S_T4;
                else
                    state_d = S_T0;
            end
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (is_mem | is_md) ? S_T6 : S_T0;
            S_T6: begin
                if (is_st)
                    state_d = S_T7;
                else if (is_ld) begin
                    if (mem_ready) state_d = S_T7;
                end else
                    state_d = S_T0;
            end
            S_T7:   if (is_ld || mem_ready) state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr)
            state_q <= S_RST;
        else
            state_q <= state_d;
    end

    // Read waits latch MDR only on the completing cycle; a reset
    // arriving in that same cycle cancels the capture.
    assign rd_wait    = (state_q == S_T1) || ((state_q == S_T6) && is_ld);
    assign mdr_enable = mdr_en_st | (rd_wait & mem_ready & clr);

    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        pc_out       = 1'b0;
        zlo_out      = 1'b0;
        zhi_out      = 1'b0;
        mdr_out      = 1'b0;
        pc_enable    = 1'b0;
        pc_increment = 1'b0;
        mar_in       = 1'b0;
        mdr_en_st    = 1'b0;
        mdr_read     = 1'b0;
        ir_enable    = 1'b0;
        y_enable     = 1'b0;
        zlo_enable   = 1'b0;
        zhi_enable   = 1'b0;
        lo_enable    = 1'b0;
        hi_enable    = 1'b0;
        gra          = 1'b0;
        grb          = 1'b0;
        grc          = 1'b0;
        r_in         = 1'b0;
        r_out        = 1'b0;
        ba_out       = 1'b0;
        c_out        = 1'b0;
        op_code      = 5'b00000;
        run          = 1'b1;
        case (state_q)
            S_T0: begin
                pc_out = 1'b1; mar_in = 1'b1; pc_increment = 1'b1;
            end
            S_T1: begin
                mem_read = 1'b1; mdr_read = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1; ir_enable = 1'b1;
            end
            S_T3: begin
                if (is_mem) begin
                    grb = 1'b1; ba_out = 1'b1; y_enable = 1'b1;
                end else if (is_r | is_addi) begin
                    grb = 1'b1; r_out = 1'b1; y_enable = 1'b1;
                end else if (is_md) begin
                    gra = 1'b1; r_out = 1'b1; y_enable = 1'b1;
                end
            end
            S_T4: begin
                if (is_r) begin
                    grc = 1'b1; r_out = 1'b1; zlo_enable = 1'b1;
                    op_code = opc;
                end else if (is_addi | is_mem) begin
                    c_out = 1'b1; zlo_enable = 1'b1;
                    op_code = 5'b00011;
                end else if (is_md) begin
                    grb = 1'b1; r_out = 1'b1;
                    zlo_enable = 1'b1; zhi_enable = 1'b1;
                    op_code = opc;
                end
            end
            S_T5: begin
                zlo_out = 1'b1;
                if (is_mem)
                    mar_in = 1'b1;
                else if (is_md)
                    lo_enable = 1'b1;
                else begin
                    gra = 1'b1; r_in = 1'b1;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    mem_read = 1'b1; mdr_read = 1'b1;
                end else if (is_st) begin
                    gra = 1'b1; r_out = 1'b1; mdr_en_st = 1'b1;
                end else if (is_md) begin
                    zhi_out = 1'b1; hi_enable = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                end else
                    mem_write = 1'b1;
            end
            S_HALT: run = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and randomized checks of control_unit against a
// queue-based micro-step model built from the instruction sequencing rules.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic        mem_ready;
    logic        mem_read, mem_write, pc_out, zlo_out, zhi_out, mdr_out;
    logic        pc_enable, pc_increment, mar_in, mdr_enable, mdr_read;
    logic        ir_enable, y_enable, zlo_enable, zhi_enable;
    logic        lo_enable, hi_enable, gra, grb, grc, r_in, r_out;
    logic        ba_out, c_out, run;
    logic [4:0]  op_code;

    control_unit dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write),
        .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out),
        .mdr_out(mdr_out), .pc_enable(pc_enable),
        .pc_increment(pc_increment), .mar_in(mar_in),
        .mdr_enable(mdr_enable), .mdr_read(mdr_read),
        .ir_enable(ir_enable), .y_enable(y_enable),
        .zlo_enable(zlo_enable), .zhi_enable(zhi_enable),
        .lo_enable(lo_enable), .hi_enable(hi_enable),
        .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out),
        .ba_out(ba_out), .c_out(c_out), .op_code(op_code), .run(run)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic mem_read, mem_write, pc_out, zlo_out, zhi_out, mdr_out;
        logic pc_enable, pc_increment, mar_in, mdr_enable, mdr_read;
        logic ir_enable, y_enable, zlo_enable, zhi_enable;
        logic lo_enable, hi_enable, gra, grb, grc, r_in, r_out;
        logic ba_out, c_out, run;
        logic [4:0] op;
    } ov_t;

    localparam int K_NORM = 0;
    localparam int K_RD   = 1;
    localparam int K_WR   = 2;
    localparam int K_HALT = 3;

    typedef struct {
        ov_t o;
        int  kind;
        int  tag;
    } step_t;

    ov_t     act;
    step_t   q[$];
    bit      nxt_exec = 1'b0;
    bit      chk_en = 1'b0;
    int      errors = 0;
    int      checks = 0;

    assign act = {mem_read, mem_write, pc_out, zlo_out, zhi_out, mdr_out,
                  pc_enable, pc_increment, mar_in, mdr_enable, mdr_read,
                  ir_enable, y_enable, zlo_enable, zhi_enable,
                  lo_enable, hi_enable, gra, grb, grc, r_in, r_out,
                  ba_out, c_out, run, op_code};

    function automatic ov_t idle();
        ov_t o = '0;
        o.run = 1'b1;
        return o;
    endfunction

    function void push(input ov_t o, input int kind, input int tag);
        step_t s;
        s.o = o; s.kind = kind; s.tag = tag;
        q.push_back(s);
    endfunction

    function void load_fetch();
        ov_t o;
        o = idle(); o.pc_out = 1; o.mar_in = 1; o.pc_increment = 1;
        push(o, K_NORM, 0);
        o = idle(); o.mem_read = 1; o.mdr_read = 1;
        push(o, K_RD, 1);
        o = idle(); o.mdr_out = 1; o.ir_enable = 1;
        push(o, K_NORM, 2);
    endfunction

    function void load_exec(input logic [4:0] opc);
        ov_t o;
        case (opc)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd12: begin
                o = idle(); o.grb = 1; o.r_out = 1; o.y_enable = 1;
                push(o, K_NORM, 3);
                o = idle(); o.zlo_enable = 1;
                if (opc == 5'd12) begin
                    o.c_out = 1; o.op = 5'd3;
                end else begin
                    o.grc = 1; o.r_out = 1; o.op = opc;
                end
                push(o, K_NORM, 4);
                o = idle(); o.zlo_out = 1; o.gra = 1; o.r_in = 1;
                push(o, K_NORM, 5);
            end
            5'd0, 5'd2: begin
                o = idle(); o.grb = 1; o.ba_out = 1; o.y_enable = 1;
                push(o, K_NORM, 3);
                o = idle(); o.c_out = 1; o.zlo_enable = 1; o.op = 5'd3;
                push(o, K_NORM, 4);
                o = idle(); o.zlo_out = 1; o.mar_in = 1;
                push(o, K_NORM, 5);
                if (opc == 5'd0) begin
                    o = idle(); o.mem_read = 1; o.mdr_read = 1;
                    push(o, K_RD, 6);
                    o = idle(); o.mdr_out = 1; o.gra = 1; o.r_in = 1;
                    push(o, K_NORM, 7);
                end else begin
                    o = idle(); o.gra = 1; o.r_out = 1; o.mdr_enable = 1;
                    push(o, K_NORM, 6);
                    o = idle(); o.mem_write = 1;
                    push(o, K_WR, 7);
                end
            end
`ifdef MUL_DIV_EN
            5'd15, 5'd16: begin
                o = idle(); o.gra = 1; o.r_out = 1; o.y_enable = 1;
                push(o, K_NORM, 3);
                o = idle(); o.grb = 1; o.r_out = 1; o.op = opc;
                o.zlo_enable = 1; o.zhi_enable = 1;
                push(o, K_NORM, 4);
                o = idle(); o.zlo_out = 1; o.lo_enable = 1;
                push(o, K_NORM, 5);
                o = idle(); o.zhi_out = 1; o.hi_enable = 1;
                push(o, K_NORM, 6);
            end
`endif
            5'd27: begin
                push(idle(), K_NORM, 3);
                o = '0;
                push(o, K_HALT, 9);
            end
            default: push(idle(), K_NORM, 3);
        endcase
    endfunction

    // Model advance: one micro-step per edge, waits hold until mem_ready.
    initial forever begin
        @(posedge clk);
        if (!clr) begin
            q.delete();
            push(idle(), K_NORM, 99);
            nxt_exec = 1'b0;
        end else if (q.size() > 0) begin
            if (q[0].kind == K_HALT) begin
            end else if ((q[0].kind == K_RD || q[0].kind == K_WR)
                         && !mem_ready) begin
            end else begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    if (nxt_exec) load_exec(ir[31:27]);
                    else load_fetch();
                    nxt_exec = !nxt_exec;
                end
            end
        end
    end

    initial forever begin
        ov_t e;
        @(negedge clk);
        if (chk_en && q.size() > 0) begin
            e = q[0].o;
            if (q[0].kind == K_RD && mem_ready && clr) e.mdr_enable = 1'b1;
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t step=%0d got=%h want=%h",
                         $time, q[0].tag, act, e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_ir();
        logic [4:0]  tbl [13];
        logic [31:0] r;
        int          idx;
        tbl = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                5'd12, 5'd15, 5'd16, 5'd26, 5'd27};
        r   = $urandom();
        idx = $urandom_range(0, 13);
        if (idx == 13) r[31:27] = 5'($urandom_range(0, 31));
        else r[31:27] = tbl[idx];
        return r;
    endfunction

`ifdef MUL_DIV_EN
    localparam int MUL_END = 7;
`else
    localparam int MUL_END = 4;
`endif

    int rd1, en1, rd2, en2, lohi, hcnt;

    initial begin
        clr = 1'b0; mem_ready = 1'b0; ir = 32'h1800_0000;
        tick();
        chk_en = 1'b1;
        tick();
        clr = 1'b1;
        @(negedge clk);
        chk("rst_outputs", act, 32'h20);
        tick();
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t0_pc_out", pc_out, 1);
        chk("t0_mar_in", mar_in, 1);
        chk("t0_pc_inc", pc_increment, 1);

        // add with mem_ready tied high
        for (int c = 1; c <= 6; c++) begin
            tick();
            @(negedge clk);
            if (c == 1) chk("add_t1_mdr_en", mdr_enable, 1);
            if (c == 4) chk("add_t4_op", op_code, 5'b00011);
            if (c == 4) chk("add_t4_zlo_en", zlo_enable, 1);
            if (c == 5) chk("add_t5", {gra, r_in, zlo_out}, 3'b111);
            if (c == 6) chk("add_next_t0", pc_out, 1);
        end

        // ld with 3 + 2 wait cycles
        ir = 32'h0000_0000;
        rd1 = 0; en1 = 0; rd2 = 0; en2 = 0;
        for (int c = 1; c <= 13; c++) begin
            tick();
            mem_ready = (c == 4 || c == 11);
            @(negedge clk);
            if (c <= 4) begin rd1 += int'(mem_read); en1 += int'(mdr_enable); end
            if (c >= 9 && c <= 11) begin
                rd2 += int'(mem_read); en2 += int'(mdr_enable);
            end
            if (c == 12) chk("ld_t7", {mdr_out, gra, r_in}, 3'b111);
            if (c == 13) chk("ld_next_t0", pc_out, 1);
        end
        chk("ld_t1_rd_cycles", rd1, 4);
        chk("ld_t1_mdr_pulses", en1, 1);
        chk("ld_t6_rd_cycles", rd2, 3);
        chk("ld_t6_mdr_pulses", en2, 1);

        // st aborted by reset during the write wait
        ir = 32'h1000_0000;
        en1 = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            mem_ready = (c == 1);
            clr = (c != 8);
            @(negedge clk);
            if (c >= 7) en1 += int'(mdr_enable);
            if (c == 6) chk("st_t6", {mdr_enable, mdr_read, r_out}, 3'b101);
            if (c == 7) chk("st_t7_wr", mem_write, 1);
            if (c == 8) chk("st_t7_wr_hold", mem_write, 1);
            if (c == 9) chk("st_abort_rst", act, 32'h20);
            if (c == 10) chk("st_restart_t0", pc_out, 1);
        end
        chk("st_abort_no_mdr", en1, 0);

        // mul
        ir = 32'h7800_0000;
        mem_ready = 1'b1;
        lohi = 0;
        for (int c = 1; c <= MUL_END; c++) begin
            tick();
            @(negedge clk);
`ifdef MUL_DIV_EN
            if (c == 5) chk("mul_t5_lo", lo_enable, 1);
            if (c == 6) chk("mul_t6_hi", hi_enable, 1);
`else
            lohi += int'(lo_enable) + int'(hi_enable);
`endif
            if (c == MUL_END) chk("mul_next_t0", pc_out, 1);
        end
        chk("mul_lohi_off", lohi, 0);

        // halt, then restart by reset
        ir = 32'hD800_0000;
        for (int c = 1; c <= 16; c++) begin
            tick();
            mem_ready = (c >= 4) ? c[0] : 1'b1;
            clr = (c != 14);
            @(negedge clk);
            if (c >= 4 && c <= 13) chk("halt_quiet", act, 32'h0);
            if (c == 16) chk("halt_restart_t0", pc_out, 1);
        end

        // randomized traffic
        hcnt = 0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            mem_ready = ($urandom_range(0, 99) < 55);
            clr = ($urandom_range(0, 299) != 0);
            if (q[0].kind == K_HALT) begin
                hcnt++;
                if (hcnt > 8) begin clr = 1'b0; hcnt = 0; end
            end else hcnt = 0;
            if (q[0].tag == 0) ir = rand_ir();
        end
        tick();
        @(negedge clk);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port clr, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port ir, input, 32 bits: instruction register contents; opcode is ir[31:27].
REQ-004 SHALL have port mem_ready, input, 1 bit: memory completes the pending read or write this cycle.
REQ-005 SHALL have ports mem_read and mem_write, outputs, 1 bit each: memory request strobes.
REQ-006 SHALL have ports pc_out, zlo_out, zhi_out and mdr_out, outputs, 1 bit each: bus-drive selects.
REQ-007 SHALL have ports pc_enable, pc_increment, mar_in, mdr_enable, mdr_read, ir_enable, y_enable, zlo_enable, zhi_enable, lo_enable and hi_enable, outputs, 1 bit each: register load strobes.
REQ-008 SHALL have ports gra, grb, grc, r_in, r_out, ba_out and c_out, outputs, 1 bit each: register-file select and encode controls.
REQ-009 SHALL have port op_code, output, 5 bits: ALU operation.
REQ-010 SHALL have port run, output, 1 bit: high unless halted.

Function
REQ-011 SHALL implement these states: T0 (pc_out, mar_in, pc_increment) -> T1 (mem_read, mdr_read) -> T2 (mdr_out, ir_enable) -> T3; op_code=00000 in T0–T2.
REQ-012 SHALL make outputs Moore functions of the state, except mdr_enable, which is asserted only in a memory-wait state during a cycle with mem_ready=1.
REQ-013 SHALL handle memory waits as follows: in T1 and in ld T6, hold mem_read=1 until mem_ready=1; the state advances on that edge, and mdr_enable=1 with mdr_read=1 in that same cycle.
REQ-014 SHALL sequence R-type add 00011, sub 00100, and 00101, or 00110, shr 00111 and shl 01000 as: T3 grb, r_out, y_enable; T4 grc, r_out, zlo_enable with op_code=ir[31:27]; T5 zlo_out, gra, r_in; then T0.
REQ-015 SHALL sequence addi 01100 as: T3 grb, r_out, y_enable; T4 c_out, zlo_enable with op_code=00011; T5 zlo_out, gra, r_in; then T0.
REQ-016 SHALL sequence ld 00000 as: T3 grb, ba_out, y_enable; T4 c_out, op_code=00011, zlo_enable; T5 zlo_out, mar_in; T6 wait-read; T7 mdr_out, gra, r_in; then T0.
REQ-017 SHALL sequence st 00010 with T3–T5 as in ld, then: T6 gra, r_out, mdr_enable with mdr_read=0; T7 hold mem_write=1 until mem_ready=1; then T0.
REQ-018 SHALL treat nop 11010 and every undefined opcode as T3 -> T0 with no strobes.
REQ-019 SHALL handle halt 11011 as: T3 -> HALT; in HALT all strobes are 0 and run=0; HALT exits only via reset.
REQ-020 SHALL never assert mem_read and mem_write together, and never assert more than one bus-drive select (pc_out, zlo_out, zhi_out, mdr_out, r_out, c_out) in the same cycle.
REQ-021 SHALL ignore mem_ready outside the wait states.

Reset
REQ-022 SHALL, when clr=0 at a rising edge, enter state RST from any state, including mid-wait, with every output 0 and run=1.
REQ-023 SHALL move from RST to T0 on the first edge with clr=1, so that T0 strobes appear one cycle after reset release.
REQ-024 SHALL drop a mem_read or mem_write aborted by reset on the cycle after the reset edge, with no mdr_enable pulse.

Configuration
REQ-025 SHALL, when MUL_DIV_EN is defined, sequence mul 01111 and div 10000 as: T3 gra, r_out, y_enable; T4 grb, r_out, zlo_enable, zhi_enable with op_code=ir[31:27]; T5 zlo_out, lo_enable; T6 zhi_out, hi_enable; then T0.
REQ-026 SHALL, when MUL_DIV_EN is undefined, treat mul and div as nop (REQ-018), and never assert lo_enable, hi_enable or zhi_enable.

Verification
REQ-027 SHALL cover: clr=0 for 2 cycles, then 1 -> all outputs 0 in RST; T0 shows pc_out=mar_in=pc_increment=1 on the next cycle.
REQ-028 SHALL cover: ir=0x18000000 (add) with mem_ready tied 1 -> T0–T5 in 6 cycles; T4 op_code=00011, zlo_enable=1; T5 gra=r_in=zlo_out=1.
REQ-029 SHALL cover: ld with mem_ready low for 3 cycles in T1 and 2 cycles in T6 -> mem_read held for 4 and 3 cycles respectively, with exactly one mdr_enable pulse each.
REQ-030 SHALL cover: st with clr=0 during T7 wait -> mem_write=0 the following cycle, the unit enters RST, and no mdr_enable is asserted.
REQ-031 SHALL cover: ir=0x78000000 (mul) -> with MUL_DIV_EN, lo_enable in T5 and hi_enable in T6; without it, T3 -> T0 with lo_enable=hi_enable=0.
REQ-032 SHALL cover: ir=0xD8000000 (halt) -> run=0 and all strobes 0 for 10 cycles despite mem_ready toggling, and a reset restarts at T0.
